// File: rtl/match_window_gen.sv
// Window generator for the block matcher: line buffers plus shift-array windows for the
// reference and search streams, emitting packed region/core windows per accepted pixel.
module match_window_gen #(
  parameter int dataDept = 4,
  parameter int Rewin_W  = 8,
  parameter int Rewin_H  = 8,
  parameter int Cowin_W  = 2,
  parameter int Cowin_H  = 2,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int XW       = $clog2(IMG_W),
  parameter int YW       = $clog2(IMG_H),
  parameter int OFF_X    = (Rewin_W - Cowin_W) / 2,
  parameter int OFF_Y    = (Rewin_H - Cowin_H) / 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sof,
  input  logic                                  pix_vld,
  input  logic [dataDept-1:0]                   ref_pix,
  input  logic [dataDept-1:0]                   srch_pix,
  output logic                                  win_vld,
  output logic [dataDept*Rewin_W*Rewin_H-1:0]   RegionWin,
  output logic [dataDept*Cowin_W*Cowin_H-1:0]   coreWin,
  output logic [XW-1:0]                         win_x,
  output logic [YW-1:0]                         win_y,
  output logic                                  frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(Rewin_W - 1);
  localparam logic [YW-1:0] Y_MIN  = YW'(Rewin_H - 1);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic          accept, last_pix, win_ok;
  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;

  logic [dataDept-1:0] ref_lb  [Rewin_H-1][IMG_W];
  logic [dataDept-1:0] srch_lb [Rewin_H-1][IMG_W];
  logic [dataDept-1:0] ref_lb_out  [Rewin_H-1];
  logic [dataDept-1:0] srch_lb_out [Rewin_H-1];

  logic [dataDept-1:0] ref_win  [Rewin_H][Rewin_W];
  logic [dataDept-1:0] srch_win [Rewin_H][Rewin_W];

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: state_nxt = WAIT_SOF;
      ACTIVE:   if (accept && last_pix) state_nxt = DONE;
      DONE:     state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
    // a qualified sof restarts the frame from any state
    if (sof && pix_vld) state_nxt = ACTIVE;
  end

  always_comb begin
    accept   = !rst && pix_vld && (sof || state == ACTIVE);
    cur_x    = sof ? '0 : x;
    cur_y    = sof ? '0 : y;
    last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
    win_ok   = accept && (cur_x >= X_MIN) && (cur_y >= Y_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      win_vld    <= 1'b0;
      frame_done <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      win_vld    <= win_ok;
      frame_done <= accept && last_pix;
      if (accept) begin
        if (cur_x == X_LAST) begin
          x <= '0;
          y <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
        end else begin
          x <= cur_x + XW'(1);
          y <= cur_y;
        end
      end
      if (win_ok) begin
        win_x <= cur_x - X_MIN;
        win_y <= cur_y - Y_MIN;
      end
    end
  end

  // Cascaded line buffers, read-before-write at cur_x; contents are never cleared.
  always_comb begin
    for (int k = 0; k < Rewin_H-1; k++) begin
      ref_lb_out[k]  = ref_lb[k][cur_x];
      srch_lb_out[k] = srch_lb[k][cur_x];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ref_lb[0][cur_x]  <= ref_pix;
      srch_lb[0][cur_x] <= srch_pix;
      for (int k = 1; k < Rewin_H-1; k++) begin
        ref_lb[k][cur_x]  <= ref_lb_out[k-1];
        srch_lb[k][cur_x] <= srch_lb_out[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < Rewin_H; r++)
        for (int c = 0; c < Rewin_W; c++) begin
          ref_win[r][c]  <= '0;
          srch_win[r][c] <= '0;
        end
    end else if (accept) begin
      for (int r = 0; r < Rewin_H; r++)
        for (int c = 0; c < Rewin_W-1; c++) begin
          ref_win[r][c]  <= ref_win[r][c+1];
          srch_win[r][c] <= srch_win[r][c+1];
        end
      for (int r = 0; r < Rewin_H-1; r++) begin
        ref_win[r][Rewin_W-1]  <= ref_lb_out[Rewin_H-2-r];
        srch_win[r][Rewin_W-1] <= srch_lb_out[Rewin_H-2-r];
      end
      ref_win[Rewin_H-1][Rewin_W-1]  <= ref_pix;
      srch_win[Rewin_H-1][Rewin_W-1] <= srch_pix;
    end
  end

  always_comb begin
    RegionWin = '0;
    coreWin   = '0;
    for (int r = 0; r < Rewin_H; r++)
      for (int c = 0; c < Rewin_W; c++)
        RegionWin[dataDept*(r*Rewin_W+c) +: dataDept] = srch_win[r][c];
    for (int r = 0; r < Cowin_H; r++)
      for (int c = 0; c < Cowin_W; c++)
        coreWin[dataDept*(r*Cowin_W+c) +: dataDept] = ref_win[r+OFF_Y][c+OFF_X];
  end

endmodule
